// File: rtl/pc_redirect_pkg.sv
// Shared types for the next-PC redirect controller.
// Optional feature macro: REDIRECT_STATS_EN (see pc_redirect_ctrl).
package pc_redirect_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_e;

    typedef enum logic [1:0] {
        FL_NONE,
        FL_IF,
        FL_IF_ID
    } flush_e;

    localparam logic [2:0] SRC_SEQ = 3'b000;
    localparam logic [2:0] SRC_BTB = 3'b001;
    localparam logic [2:0] SRC_ID  = 3'b010;
    localparam logic [2:0] SRC_EX  = 3'b100;

    typedef struct packed {
        logic        valid;
        logic [31:0] target;
        logic [2:0]  src;
        flush_e      cls;
        logic        mispred;
    } redir_t;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Redirect request / next-PC bundle between the pipeline and the PC controller.
// slave = controller side, master = pipeline side.
interface pc_redirect_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      PCPlus4;
    logic             BtbHit;
    logic [31:0]      BtbTarget;
    logic             JumpValid;
    logic [31:0]      JumpAddress;
    logic             JrValid;
    logic [31:0]      JrAddress;
    logic             BranchResolve;
    logic             BranchTaken;
    logic             BranchPredTaken;
    logic [31:0]      BranchTarget;
    logic [31:0]      BranchPC;
    logic             PCWriteEn;
    logic [31:0]      NextPC;
    logic             PCLoad;
    logic             FlushIF;
    logic             FlushID;
    logic [2:0]       RedirectSrc;
    logic             BtbUpdate;
    logic             BtbUpdateTaken;
    logic [31:0]      BtbUpdatePC;
    logic [31:0]      BtbUpdateTarget;
    logic [CNT_W-1:0] MispredCount;
    logic [CNT_W-1:0] RedirectCount;

    modport slave (
        input  PCPlus4, BtbHit, BtbTarget,
        input  JumpValid, JumpAddress,
        input  JrValid, JrAddress,
        input  BranchResolve, BranchTaken,
        input  BranchPredTaken, BranchTarget,
        input  BranchPC, PCWriteEn,
        output NextPC, PCLoad,
        output FlushIF, FlushID, RedirectSrc,
        output BtbUpdate, BtbUpdateTaken,
        output BtbUpdatePC, BtbUpdateTarget,
        output MispredCount, RedirectCount
    );

    modport master (
        output PCPlus4, BtbHit, BtbTarget,
        output JumpValid, JumpAddress,
        output JrValid, JrAddress,
        output BranchResolve, BranchTaken,
        output BranchPredTaken, BranchTarget,
        output BranchPC, PCWriteEn,
        input  NextPC, PCLoad,
        input  FlushIF, FlushID, RedirectSrc,
        input  BtbUpdate, BtbUpdateTaken,
        input  BtbUpdatePC, BtbUpdateTarget,
        input  MispredCount, RedirectCount
    );

endinterface

// File: rtl/redirect_prio_enc.sv
// Fixed-priority select among mispredict, jr, jump, BTB hit and PC+4.
// Produces target, one-hot source and flush class of the winner.
module redirect_prio_enc
    import pc_redirect_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_address,
    input  logic        jr_valid,
    input  logic [31:0] jr_address,
    input  logic        br_resolve,
    input  logic        br_taken,
    input  logic        br_pred_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] br_pc,
    output redir_t      req
);

    logic        mispred;
    logic [31:0] mis_target;

    // Winner of the current cycle; losers are simply not looked at.
    always_comb begin
        mispred    = br_resolve & (br_taken ^ br_pred_taken);
        mis_target = br_taken ? br_target : (br_pc + 32'd4);
        req        = '{valid: 1'b0, target: pc_plus4,
                       src: SRC_SEQ, cls: FL_NONE,
                       mispred: 1'b0};
        priority case (1'b1)
            mispred: begin
                req = '{valid: 1'b1, target: mis_target,
                        src: SRC_EX, cls: FL_IF_ID,
                        mispred: 1'b1};
            end
            jr_valid: begin
                req = '{valid: 1'b1, target: jr_address,
                        src: SRC_EX, cls: FL_IF_ID,
                        mispred: 1'b0};
            end
            jump_valid: begin
                req = '{valid: 1'b1, target: jump_address,
                        src: SRC_ID, cls: FL_IF,
                        mispred: 1'b0};
            end
            btb_hit: begin
                req = '{valid: 1'b1, target: btb_target,
                        src: SRC_BTB, cls: FL_NONE,
                        mispred: 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC controller: redirect arbitration, stall hold, flushes, BTB update.
// Optional: REDIRECT_STATS_EN adds saturating mispredict/redirect counters.
module pc_redirect_ctrl
    import pc_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 32
) (
    input logic               Clk,
    input logic               Reset_n,
    pc_redirect_ctrl_if.slave bus
);

    redir_t      req;
    redir_t      sel;
    logic        ex_req;
    logic        holdable;
    logic        we;

    state_e      state_q, state_d;
    redir_t      hold_q, hold_d;
    logic        upd_q, upd_d;
    logic        upd_taken_q, upd_taken_d;
    logic [31:0] upd_pc_q, upd_pc_d;
    logic [31:0] upd_tgt_q, upd_tgt_d;

    redirect_prio_enc u_prio (
        .pc_plus4      (bus.PCPlus4),
        .btb_hit       (bus.BtbHit),
        .btb_target    (bus.BtbTarget),
        .jump_valid    (bus.JumpValid),
        .jump_address  (bus.JumpAddress),
        .jr_valid      (bus.JrValid),
        .jr_address    (bus.JrAddress),
        .br_resolve    (bus.BranchResolve),
        .br_taken      (bus.BranchTaken),
        .br_pred_taken (bus.BranchPredTaken),
        .br_target     (bus.BranchTarget),
        .br_pc         (bus.BranchPC),
        .req           (req)
    );

    // Pick live request or held one; a fresh EX redirect supersedes the hold
    // because it always belongs to the oldest instruction in flight.
    always_comb begin
        we       = bus.PCWriteEn;
        ex_req   = req.valid & (req.src == SRC_EX);
        holdable = req.valid & ((req.src == SRC_EX) | (req.src == SRC_ID));
        sel      = req;
        if (state_q == ST_PEND && !ex_req) begin
            sel = hold_q;
        end
    end

    // Outputs are forced to their reset values while Reset_n is low.
    always_comb begin
        bus.NextPC          = RESET_VECTOR;
        bus.PCLoad          = 1'b0;
        bus.RedirectSrc     = SRC_SEQ;
        bus.FlushIF         = 1'b0;
        bus.FlushID         = 1'b0;
        bus.BtbUpdate       = 1'b0;
        bus.BtbUpdateTaken  = 1'b0;
        bus.BtbUpdatePC     = 32'd0;
        bus.BtbUpdateTarget = 32'd0;
        if (Reset_n) begin
            bus.NextPC          = sel.target;
            bus.PCLoad          = we;
            bus.RedirectSrc     = sel.src;
            bus.FlushIF         = we & (sel.cls != FL_NONE);
            bus.FlushID         = we & (sel.cls == FL_IF_ID);
            bus.BtbUpdate       = upd_q;
            bus.BtbUpdateTaken  = upd_taken_q;
            bus.BtbUpdatePC     = upd_pc_q;
            bus.BtbUpdateTarget = upd_tgt_q;
        end
    end

    // Next-state: IDLE/PEND hold logic and BTB update capture.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        upd_d       = bus.BranchResolve & we;
        upd_taken_d = upd_taken_q;
        upd_pc_d    = upd_pc_q;
        upd_tgt_d   = upd_tgt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!we && holdable) begin
                    state_d = ST_PEND;
                    hold_d  = req;
                end
            end
            ST_PEND: begin
                if (we) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else if (ex_req) begin
                    hold_d = req;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (upd_d) begin
            upd_taken_d = bus.BranchTaken;
            upd_pc_d    = bus.BranchPC;
            upd_tgt_d   = bus.BranchTarget;
        end
    end

    // FSM, hold register and BTB update registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            upd_q       <= 1'b0;
            upd_taken_q <= 1'b0;
            upd_pc_q    <= 32'd0;
            upd_tgt_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            upd_q       <= upd_d;
            upd_taken_q <= upd_taken_d;
            upd_pc_q    <= upd_pc_d;
            upd_tgt_q   <= upd_tgt_d;
        end
    end

`ifdef REDIRECT_STATS_EN
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic [CNT_W-1:0] red_cnt_q, red_cnt_d;
    logic             app_redir;

    // Count applied EX/ID redirects, saturating at all-ones.
    always_comb begin
        app_redir = we & sel.valid & (sel.src != SRC_BTB);
        mis_cnt_d = mis_cnt_q;
        red_cnt_d = red_cnt_q;
        if (app_redir && red_cnt_q != '1) begin
            red_cnt_d = red_cnt_q + CNT_W'(1);
        end
        if (app_redir && sel.mispred && mis_cnt_q != '1) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end
    end

    // Statistics counter registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mis_cnt_q <= '0;
            red_cnt_q <= '0;
        end else begin
            mis_cnt_q <= mis_cnt_d;
            red_cnt_q <= red_cnt_d;
        end
    end

    assign bus.MispredCount  = mis_cnt_q;
    assign bus.RedirectCount = red_cnt_q;
`else
    assign bus.MispredCount  = {CNT_W{1'b0}};
    assign bus.RedirectCount = {CNT_W{1'b0}};
`endif

endmodule
